// File: rtl/alu_seq_responder.sv
// ALU request/response front end. Logic and arithmetic ops go through a shared
// combinational alu in one cycle; shifts iterate one bit per cycle. One op in flight.

package alu_types_pkg;
   typedef enum logic [3:0] {
      ALU_AND = 4'h0,
      ALU_OR  = 4'h1,
      ALU_ADD = 4'h2,
      ALU_XOR = 4'h3,
      ALU_NOR = 4'h4,
      ALU_SUB = 4'h6,
      ALU_SLT = 4'h7,
      ALU_SLL = 4'h8,
      ALU_SRL = 4'h9,
      ALU_SRA = 4'hA
   } alu_control_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_RESP  = 2'd2
   } rsp_state_t;
endpackage

module alu
   import alu_types_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  alu_control_t control,
   output logic [N-1:0] y,
   output logic         overflow
);
   logic [N-1:0] sum;
   logic [N-1:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      y        = '0;
      overflow = 1'b0;
      case (control)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_NOR: y = ~(a | b);
         ALU_ADD: begin
            y        = sum;
            overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
         end
         ALU_SUB: begin
            y        = diff;
            overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
         end
         ALU_SLT: y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
         // Shifts are sequenced by the responder; unknown codes produce 0.
         default: y = '0;
      endcase
   end
endmodule

module alu_seq_responder
   import alu_types_pkg::*;
#(
   parameter int N     = 32,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [N-1:0]     req_a,
   input  logic [N-1:0]     req_b,
   input  alu_control_t     req_control,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [N-1:0]     rsp_result,
   output logic             rsp_overflow,
   output logic             rsp_zero,
   output logic             rsp_equal,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [CNT_W-1:0] ops_done,
   output rsp_state_t       dbg_state
);
   // Handshakes: a transfer happens on a clk edge where valid && ready are both
   // high; a source holds valid and its payload stable until that edge, and
   // ready never depends combinationally on the partner's valid.

   rsp_state_t   state;
   rsp_state_t   state_next;
   alu_control_t op_q;
   logic [N-1:0] work;
   logic [N-1:0] work_next;
   logic [4:0]   cnt;
   logic [4:0]   shamt;
   logic [N-1:0] alu_y;
   logic         alu_ov;
   logic         accept;
   logic         is_shift;
   logic         rsp_hs;

   alu #(.N(N)) u_alu (
      .a        (req_a),
      .b        (req_b),
      .control  (req_control),
      .y        (alu_y),
      .overflow (alu_ov)
   );

   assign shamt     = req_b[4:0];
   assign is_shift  = (req_control == ALU_SLL) || (req_control == ALU_SRL) ||
                      (req_control == ALU_SRA);
   assign accept    = req_valid && req_ready && (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign rsp_hs    = rsp_valid && rsp_ready;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_shift && (shamt != 5'd0)) state_next = ST_SHIFT;
               else                             state_next = ST_RESP;
            end
         end
         ST_SHIFT: if (cnt == 5'd1) state_next = ST_RESP;
         ST_RESP:  if (rsp_ready)   state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Registered so that req_ready is low throughout reset and has no path from rsp_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) req_ready <= 1'b0;
      else        req_ready <= (state_next == ST_IDLE);
   end

   always_comb begin
      work_next = work;
      case (op_q)
         ALU_SLL: work_next = {work[N-2:0], 1'b0};
         ALU_SRL: work_next = {1'b0, work[N-1:1]};
         ALU_SRA: work_next = {work[N-1], work[N-1:1]};
         default: work_next = work;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q         <= ALU_AND;
         work         <= '0;
         cnt          <= '0;
         rsp_result   <= '0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_equal    <= 1'b0;
         rsp_tag      <= '0;
      end else if (accept) begin
         op_q      <= req_control;
         rsp_tag   <= req_tag;
         rsp_equal <= (req_a == req_b);
         if (is_shift) begin
            if (shamt == 5'd0) begin
               rsp_result   <= req_a;
               rsp_overflow <= 1'b0;
               rsp_zero     <= (req_a == '0);
            end else begin
               work <= req_a;
               cnt  <= shamt;
            end
         end else begin
            rsp_result   <= alu_y;
            rsp_overflow <= alu_ov;
            rsp_zero     <= (alu_y == '0);
         end
      end else if (state == ST_SHIFT) begin
         work <= work_next;
         cnt  <= cnt - 5'd1;
         if (cnt == 5'd1) begin
            rsp_result   <= work_next;
            rsp_overflow <= 1'b0;
            rsp_zero     <= (work_next == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ops_done <= '0;
      else if (rsp_hs) ops_done <= ops_done + CNT_W'(1);
   end
endmodule

// File: tb/tb_alu_seq_responder.sv
// Bench for alu_seq_responder: directed cases plus randomized traffic against an
// arithmetic reference model, checked by a queue-based response monitor.

module tb_alu_seq_responder;
   import alu_types_pkg::*;

   localparam int N     = 32;
   localparam int TAG_W = 4;
   localparam int CNT_W = 16;
   // expected entry: {latency[4:0], tag, equal, zero, overflow, result}
   localparam int EW    = 5 + TAG_W + 3 + N;
   localparam longint MAX_S = 64'sh0000_0000_7FFF_FFFF;
   localparam longint MIN_S = -64'sh0000_0000_8000_0000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [N-1:0]     req_a = '0;
   logic [N-1:0]     req_b = '0;
   alu_control_t     req_control = ALU_AND;
   logic [TAG_W-1:0] req_tag = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [N-1:0]     rsp_result;
   logic             rsp_overflow;
   logic             rsp_zero;
   logic             rsp_equal;
   logic [TAG_W-1:0] rsp_tag;
   logic [CNT_W-1:0] ops_done;
   rsp_state_t       dbg_state;

   logic [EW-1:0] exp_q[$];
   int            acc_q[$];
   int            total = 0;
   int            bad = 0;
   int            hs_count = 0;
   int            cyc = 0;
   logic          in_resp = 1'b0;
   logic          rand_mode = 1'b0;
   logic [EW-1:0] cur;
   int            acc;

   alu_seq_responder #(.N(N), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_control  (req_control),
      .req_tag      (req_tag),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_overflow (rsp_overflow),
      .rsp_zero     (rsp_zero),
      .rsp_equal    (rsp_equal),
      .rsp_tag      (rsp_tag),
      .ops_done     (ops_done),
      .dbg_state    (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s got=timeout want=event (t=%0t)", name, $time);
   endtask

   // Reference model: results from plain arithmetic on the operation's meaning.
   function automatic logic [EW-1:0] model_rsp(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic [3:0] op, input logic [TAG_W-1:0] tag);
      longint       sa;
      longint       sb;
      longint       wide;
      logic [N-1:0] res;
      logic         ov;
      logic [4:0]   lat;
      int           s;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = '0;
      ov  = 1'b0;
      lat = 5'd0;
      s   = int'(b % 32);
      case (alu_control_t'(op))
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_XOR: res = a ^ b;
         ALU_NOR: res = ~(a | b);
         ALU_ADD: begin
            wide = sa + sb;
            res  = a + b;
            ov   = (wide > MAX_S) || (wide < MIN_S);
         end
         ALU_SUB: begin
            wide = sa - sb;
            res  = a - b;
            ov   = (wide > MAX_S) || (wide < MIN_S);
         end
         ALU_SLT: res = (sa < sb) ? 32'd1 : 32'd0;
         ALU_SLL: begin res = a << s; lat = 5'(s); end
         ALU_SRL: begin res = a >> s; lat = 5'(s); end
         ALU_SRA: begin res = N'($signed(a) >>> s); lat = 5'(s); end
         default: res = '0;
      endcase
      return {lat, tag, (a == b), (res == '0), ov, res};
   endfunction

   // driver: call at posedge+1; returns at posedge+1 after the accept edge
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [3:0] op, input logic [TAG_W-1:0] tag);
      int waited = 0;
      req_a       = a;
      req_b       = b;
      req_control = alu_control_t'(op);
      req_tag     = tag;
      req_valid   = 1'b1;
      while (!req_ready && waited < 300) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!req_ready) begin
         timeout_fail("req_ready_wait");
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back(model_rsp(a, b, op, tag));
      @(posedge clk); #1;
      acc_q.push_back(cyc);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) timeout_fail("drain_wait");
   endtask

   always @(posedge clk) begin
      #1;
      if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         in_resp = 1'b0;
      end else if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp got=tag%h want=none (t=%0t)", rsp_tag, $time);
         end else begin
            cur = exp_q[0];
            if (!in_resp) begin
               in_resp = 1'b1;
               if (acc_q.size() != 0) begin
                  acc = acc_q.pop_front();
                  chk("latency", 64'(cyc - acc), 64'(cur[EW-1 -: 5]));
               end
            end
            chk("rsp_fields", 64'({rsp_tag, rsp_equal, rsp_zero, rsp_overflow, rsp_result}),
                64'(cur[EW-6:0]));
            if (rsp_ready) begin
               void'(exp_q.pop_front());
               hs_count++;
               in_resp = 1'b0;
            end
         end
      end
   end

   alu_control_t op_tab[13] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SUB, ALU_SLT,
                                ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_SRA};

   initial begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [3:0]   op;
      int           n;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({rsp_valid, req_ready, rsp_result, rsp_overflow, rsp_zero,
                                rsp_equal, rsp_tag, ops_done}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("ready_after_reset", 64'(req_ready), 64'd1);

      rsp_ready = 1'b1;
      issue(32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 4'h3);
      wait_drain();
      chk("ops_done_after_add", 64'(ops_done), 64'(hs_count));

      issue(32'h1234_5678, 32'h1234_5678, ALU_SUB, 4'h5);
      issue(32'h8000_0000, 32'h0000_001F, ALU_SRA, 4'h6);
      issue(32'hA5A5_0F0F, 32'h0000_0020, ALU_SLL, 4'h7);
      issue(32'hFFFF_FFFF, 32'h0000_0001, ALU_SLT, 4'h8);
      issue(32'h8000_0000, 32'h0000_0001, ALU_SUB, 4'h9);
      issue(32'h0000_0001, 32'hFFFF_FFE1, ALU_SLL, 4'h1);
      issue(32'h0123_4567, 32'h0000_0000, 4'hF, 4'hC);
      wait_drain();

      // backpressure: response held, second request must wait
      rsp_ready = 1'b0;
      issue(32'hFFFF_0000, 32'h1234_5678, ALU_AND, 4'hA);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rsp_valid) timeout_fail("bp_valid_wait");
      req_a       = 32'h0000_00F0;
      req_b       = 32'h0000_000F;
      req_control = ALU_OR;
      req_tag     = 4'hB;
      req_valid   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         chk("bp_valid_held", 64'(rsp_valid), 64'd1);
      end
      chk("bp_ops_done", 64'(ops_done), 64'(hs_count));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_next", 64'(req_ready), 64'd1);
      issue(32'h0000_00F0, 32'h0000_000F, ALU_OR, 4'hB);
      wait_drain();

      // reset in the middle of a shift
      issue(32'hDEAD_BEEF, 32'h0000_0010, ALU_SRL, 4'h2);
      repeat (5) @(posedge clk);
      #2;
      chk("mid_shift_state", 64'(dbg_state), 64'(ST_SHIFT));
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", 64'({rsp_valid, req_ready, rsp_result, rsp_overflow, rsp_zero,
                                rsp_equal, rsp_tag, ops_done}), 64'd0);
      exp_q.delete();
      acc_q.delete();
      hs_count = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      issue(32'hF0F0_F0F0, 32'hFFFF_FFFF, ALU_XOR, 4'h4);
      wait_drain();
      chk("ops_done_after_abort", 64'(ops_done), 64'd1);

      // randomized traffic with random response stalls
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 15) < 14) op = op_tab[$urandom_range(0, 12)];
         else                            op = 4'($urandom_range(0, 15));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? a : $urandom;
         if ($urandom_range(0, 15) == 0) a = '0;
         issue(a, b, op, 4'($urandom_range(0, 15)));
      end
      wait_drain();
      rand_mode = 1'b0;
      @(posedge clk); #1;
      chk("ops_done_final", 64'(ops_done), 64'(hs_count[CNT_W-1:0]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
